// File: rtl/fifo_flex.sv
// fifo_flex: parametrised synchronous FIFO, arbitrary depth, FWFT or registered read, flush, sticky errors.
// Ports: clk_i/rst_i (sync, active-high), flush_i; write side data_i/wr_en_i; read side rd_en_i/data_o/valid_o;
// status full_o, empty_o, almost_full_o, almost_empty_o, count_o; sticky overflow_o/underflow_o.
module fifo_flex #(
   parameter int DATA_WIDTH    = 32,
   parameter int DATA_DEPTH    = 8,
   parameter int AFULL_THRESH  = DATA_DEPTH - 1,
   parameter int AEMPTY_THRESH = 1,
   parameter bit FWFT          = 1'b1,
   parameter int CW            = $clog2(DATA_DEPTH + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  wr_en_i,
   input  logic                  rd_en_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  valid_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic                  almost_full_o,
   output logic                  almost_empty_o,
   output logic [CW-1:0]         count_o,
   output logic                  overflow_o,
   output logic                  underflow_o
);
   localparam int PW = $clog2(DATA_DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DATA_DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AFULL_THRESH);
   localparam logic [CW-1:0] AE_C    = CW'(AEMPTY_THRESH);
   localparam logic [PW-1:0] LAST_C  = PW'(DATA_DEPTH - 1);
   logic [DATA_WIDTH-1:0] r_mem [DATA_DEPTH];
   logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]         r_count;
   logic                  r_ovf, r_udf;
   logic                  w_rd_acc, w_wr_acc;
   assign full_o         = r_count == DEPTH_C;
   assign empty_o        = r_count == '0;
   assign almost_full_o  = r_count >= AF_C;
   assign almost_empty_o = r_count <= AE_C;
   assign count_o        = r_count;
   assign overflow_o     = r_ovf;
   assign underflow_o    = r_udf;
   // a read frees a slot in the same cycle, so a full FIFO can still accept a concurrent write
   assign w_rd_acc = rd_en_i && !empty_o;
   assign w_wr_acc = wr_en_i && (!full_o || w_rd_acc);
   always_ff @(posedge clk_i)
      if (w_wr_acc && !rst_i && !flush_i) r_mem[r_wr_ptr] <= data_i;
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
      end else begin
         if (w_wr_acc) r_wr_ptr <= r_wr_ptr == LAST_C ? '0 : r_wr_ptr + 1'b1;
         if (w_rd_acc) r_rd_ptr <= r_rd_ptr == LAST_C ? '0 : r_rd_ptr + 1'b1;
         r_count <= r_count + CW'(w_wr_acc) - CW'(w_rd_acc);
         r_ovf   <= r_ovf | (wr_en_i && !w_wr_acc);
         r_udf   <= r_udf | (rd_en_i && empty_o);
      end
   end
   generate
      if (FWFT) begin : g_fwft
         assign data_o  = r_mem[r_rd_ptr];
         assign valid_o = !empty_o;
      end else begin : g_reg
         logic [DATA_WIDTH-1:0] r_data;
         logic                  r_valid;
         // flush drops valid but keeps the last word on data_o
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               r_data  <= '0;
               r_valid <= 1'b0;
            end else if (flush_i) begin
               r_valid <= 1'b0;
            end else begin
               r_valid <= w_rd_acc;
               if (w_rd_acc) r_data <= r_mem[r_rd_ptr];
            end
         end
         assign data_o  = r_data;
         assign valid_o = r_valid;
      end
   endgenerate
endmodule

// File: tb/tb_fifo_flex.sv
// tb_fifo_flex: self-checking bench for fifo_flex, depth 5, FWFT and registered-read instances.
module tb_fifo_flex;
   localparam int DW = 8;
   localparam int DEPTH = 5;
   typedef struct {
      logic wr, rd, fl;
      logic [DW-1:0] d;
      logic [2:0] cnt;
      logic full, empty, af, ae, ovf, udf;
   } vec_t;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;
   logic a_flush, a_wr, a_rd, a_valid, a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
   logic [DW-1:0] a_din, a_dout;
   logic [2:0] a_cnt;
   logic b_flush, b_wr, b_rd, b_valid, b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
   logic [DW-1:0] b_din, b_dout;
   logic [2:0] b_cnt;
   fifo_flex #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .AFULL_THRESH(4), .AEMPTY_THRESH(1), .FWFT(1'b1)) u_a (
      .clk_i(clk), .rst_i(rst), .flush_i(a_flush), .data_i(a_din), .wr_en_i(a_wr), .rd_en_i(a_rd),
      .data_o(a_dout), .valid_o(a_valid), .full_o(a_full), .empty_o(a_empty), .almost_full_o(a_af),
      .almost_empty_o(a_ae), .count_o(a_cnt), .overflow_o(a_ovf), .underflow_o(a_udf));
   fifo_flex #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .AFULL_THRESH(4), .AEMPTY_THRESH(1), .FWFT(1'b0)) u_b (
      .clk_i(clk), .rst_i(rst), .flush_i(b_flush), .data_i(b_din), .wr_en_i(b_wr), .rd_en_i(b_rd),
      .data_o(b_dout), .valid_o(b_valid), .full_o(b_full), .empty_o(b_empty), .almost_full_o(b_af),
      .almost_empty_o(b_ae), .count_o(b_cnt), .overflow_o(b_ovf), .underflow_o(b_udf));
   wire [9:0] a_st = {a_cnt, a_full, a_empty, a_af, a_ae, a_ovf, a_udf, a_valid};
   wire [9:0] b_st = {b_cnt, b_full, b_empty, b_af, b_ae, b_ovf, b_udf, b_valid};
   localparam logic [9:0] RST_ST = {3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
   int checks = 0;
   int failures = 0;
   logic [DW-1:0] qa[$];
   logic [DW-1:0] qb[$];
   vec_t v[$];
   logic rd_ok;
   logic [DW-1:0] exp_d;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   initial begin
      rst = 1'b1;
      {a_flush, a_wr, a_rd, a_din} = '0;
      {b_flush, b_wr, b_rd, b_din} = '0;
      tick();
      tick();
      rst = 1'b0;
      chk("a_reset_status", 32'(a_st), 32'(RST_ST));
      chk("b_reset_status", 32'(b_st), 32'(RST_ST));
      chk("b_reset_data", 32'(b_dout), 32'h0);
      // wr rd fl data | cnt full empty af ae ovf udf
      v.push_back('{1, 0, 0, 8'h01, 3'd1, 0, 0, 0, 1, 0, 0});
      v.push_back('{1, 0, 0, 8'h02, 3'd2, 0, 0, 0, 0, 0, 0});
      v.push_back('{1, 0, 0, 8'h03, 3'd3, 0, 0, 0, 0, 0, 0});
      v.push_back('{1, 0, 0, 8'h04, 3'd4, 0, 0, 1, 0, 0, 0});
      v.push_back('{1, 0, 0, 8'h05, 3'd5, 1, 0, 1, 0, 0, 0});
      v.push_back('{1, 0, 0, 8'h06, 3'd5, 1, 0, 1, 0, 1, 0});
      v.push_back('{0, 1, 0, 8'h00, 3'd4, 0, 0, 1, 0, 1, 0});
      v.push_back('{0, 1, 0, 8'h00, 3'd3, 0, 0, 0, 0, 1, 0});
      v.push_back('{0, 1, 0, 8'h00, 3'd2, 0, 0, 0, 0, 1, 0});
      v.push_back('{0, 1, 0, 8'h00, 3'd1, 0, 0, 0, 1, 1, 0});
      v.push_back('{0, 1, 0, 8'h00, 3'd0, 0, 1, 0, 1, 1, 0});
      v.push_back('{0, 1, 0, 8'h00, 3'd0, 0, 1, 0, 1, 1, 1});
      v.push_back('{0, 0, 1, 8'h00, 3'd0, 0, 1, 0, 1, 0, 0});
      v.push_back('{1, 0, 0, 8'h10, 3'd1, 0, 0, 0, 1, 0, 0});
      v.push_back('{1, 0, 0, 8'h11, 3'd2, 0, 0, 0, 0, 0, 0});
      v.push_back('{1, 0, 0, 8'h12, 3'd3, 0, 0, 0, 0, 0, 0});
      v.push_back('{1, 0, 0, 8'h13, 3'd4, 0, 0, 1, 0, 0, 0});
      v.push_back('{1, 0, 0, 8'h14, 3'd5, 1, 0, 1, 0, 0, 0});
      v.push_back('{1, 1, 0, 8'hA5, 3'd5, 1, 0, 1, 0, 0, 0});
      v.push_back('{0, 1, 0, 8'h00, 3'd4, 0, 0, 1, 0, 0, 0});
      v.push_back('{0, 1, 0, 8'h00, 3'd3, 0, 0, 0, 0, 0, 0});
      v.push_back('{0, 1, 0, 8'h00, 3'd2, 0, 0, 0, 0, 0, 0});
      v.push_back('{0, 1, 0, 8'h00, 3'd1, 0, 0, 0, 1, 0, 0});
      v.push_back('{0, 1, 0, 8'h00, 3'd0, 0, 1, 0, 1, 0, 0});
      v.push_back('{1, 1, 0, 8'h33, 3'd1, 0, 0, 0, 1, 0, 1});
      v.push_back('{1, 0, 0, 8'h44, 3'd2, 0, 0, 0, 0, 0, 1});
      v.push_back('{1, 0, 0, 8'h55, 3'd3, 0, 0, 0, 0, 0, 1});
      v.push_back('{1, 0, 1, 8'h66, 3'd0, 0, 1, 0, 1, 0, 0});
      v.push_back('{1, 0, 0, 8'h77, 3'd1, 0, 0, 0, 1, 0, 0});
      v.push_back('{0, 1, 0, 8'h00, 3'd0, 0, 1, 0, 1, 0, 0});
      for (int i = 0; i < v.size(); i++) begin
         a_wr = v[i].wr;
         a_rd = v[i].rd;
         a_flush = v[i].fl;
         a_din = v[i].d;
         if (v[i].fl) begin
            qa.delete();
         end else begin
            rd_ok = v[i].rd && qa.size() > 0;
            if (rd_ok) begin
               exp_d = qa.pop_front();
               chk($sformatf("a_data[%0d]", i), 32'(a_dout), 32'(exp_d));
            end
            if (v[i].wr && qa.size() < DEPTH) qa.push_back(v[i].d);
         end
         tick();
         chk($sformatf("a_status[%0d]", i), 32'(a_st),
             32'({v[i].cnt, v[i].full, v[i].empty, v[i].af, v[i].ae, v[i].ovf, v[i].udf, !v[i].empty}));
      end
      {a_wr, a_rd, a_flush} = '0;
      b_wr = 1'b1;
      b_din = 8'h11;
      qb.push_back(b_din);
      tick();
      b_din = 8'h22;
      qb.push_back(b_din);
      tick();
      b_wr = 1'b0;
      chk("b_count2", 32'(b_cnt), 32'd2);
      b_rd = 1'b1;
      tick();
      b_rd = 1'b0;
      exp_d = qb.pop_front();
      chk("b_valid_after_rd", 32'(b_valid), 32'd1);
      chk("b_data_first", 32'(b_dout), 32'(exp_d));
      tick();
      chk("b_valid_drop", 32'(b_valid), 32'd0);
      chk("b_data_hold", 32'(b_dout), 32'(exp_d));
      b_rd = 1'b1;
      tick();
      b_rd = 1'b0;
      exp_d = qb.pop_front();
      chk("b_data_second", 32'(b_dout), 32'(exp_d));
      chk("b_valid_second", 32'(b_valid), 32'd1);
      b_rd = 1'b1;
      tick();
      b_rd = 1'b0;
      chk("b_underflow", 32'({b_udf, b_valid, b_empty}), 32'b101);
      chk("b_data_hold_empty", 32'(b_dout), 32'(exp_d));
      b_flush = 1'b1;
      tick();
      b_flush = 1'b0;
      chk("b_flush_status", 32'(b_st), 32'(RST_ST));
      chk("b_flush_data_hold", 32'(b_dout), 32'(exp_d));
      a_wr = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a_din = 8'(8'h40 + i);
         tick();
      end
      a_wr = 1'b0;
      chk("a_count4", 32'(a_cnt), 32'd4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      qa.delete();
      chk("a_midreset_status", 32'(a_st), 32'(RST_ST));
      a_wr = 1'b1;
      a_din = 8'h07;
      qa.push_back(a_din);
      tick();
      a_wr = 1'b0;
      exp_d = qa.pop_front();
      chk("a_after_reset_data", 32'({a_valid, a_cnt, a_dout}), 32'({1'b1, 3'd1, exp_d}));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
